// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   - PC_W / INSTR_W / LUT_IDX_W : address, machine-word and LUT-index widths
//   - HALT_CODE                  : machine word that ends a program
//   - fetch_state_t              : fetch FSM states
//   - fetch_regs_t               : fetch datapath registers
//   - BRANCH_TABLE               : branch-target table produced by the assembler flow
//   - pc_inc()                   : PC increment, wraps modulo 2^PC_W
package fetch_pkg;

    localparam int PC_W      = 10;
    localparam int INSTR_W   = 9;
    localparam int LUT_IDX_W = 5;
    localparam int LUT_DEPTH = 1 << LUT_IDX_W;

    localparam logic [INSTR_W-1:0] HALT_CODE = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // pc       : next address to fetch
    // instr_pc : address of the word currently on Rom_data
    // vld      : word on Rom_data is on the correct path (cleared for the squash bubble)
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] instr_pc;
        logic            vld;
    } fetch_regs_t;

    // Branch-target table, index 31 first. Entry i holds i*8, except the last
    // entry, which points near the top of the address space.
    localparam logic [LUT_DEPTH-1:0][PC_W-1:0] BRANCH_TABLE = {
        10'h3FE, 10'h0F0, 10'h0E8, 10'h0E0, 10'h0D8, 10'h0D0, 10'h0C8, 10'h0C0,
        10'h0B8, 10'h0B0, 10'h0A8, 10'h0A0, 10'h098, 10'h090, 10'h088, 10'h080,
        10'h078, 10'h070, 10'h068, 10'h060, 10'h058, 10'h050, 10'h048, 10'h040,
        10'h038, 10'h030, 10'h028, 10'h020, 10'h018, 10'h010, 10'h008, 10'h000
    };

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut: combinational branch-target lookup.
//   target_idx : in  LUT_IDX_W  table index from the resolving branch
//   target     : out PC_W       branch target address
module branch_lut
    import fetch_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] target_idx,
    output logic [PC_W-1:0]      target
);

    assign target = BRANCH_TABLE[target_idx];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the control decoder.
// Owns the PC, drives a synchronous ROM (1-cycle read latency), handles
// stall, taken-branch redirect with a one-bubble squash, and the Start/Done
// run handshake.
//   Clk          : in  clock, rising edge
//   Reset        : in  synchronous, active-high
//   Start        : in  run request pulse, honoured in IDLE / HALTED
//   Stall        : in  downstream not consuming, hold current instruction
//   Branch_taken : in  taken branch resolved for the current Instr
//   Target_idx   : in  branch-target table index
//   Rom_addr     : out ROM read address
//   Rom_data     : in  ROM word, valid the cycle after Rom_addr
//   Instr        : out word to decode (Rom_data)
//   Instr_valid  : out Instr is live and not squashed
//   Instr_pc     : out address Instr was fetched from
//   Prog_ctr     : out current PC register
//   Done         : out high while HALTED
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 Branch_taken,
    input  logic [LUT_IDX_W-1:0] Target_idx,
    output logic [PC_W-1:0]      Rom_addr,
    input  logic [INSTR_W-1:0]   Rom_data,
    output logic [INSTR_W-1:0]   Instr,
    output logic                 Instr_valid,
    output logic [PC_W-1:0]      Instr_pc,
    output logic [PC_W-1:0]      Prog_ctr,
    output logic                 Done
);

    fetch_state_t    state, state_nxt;
    fetch_regs_t     r, r_nxt;
    logic [PC_W-1:0] br_target;
    logic            live;
    logic            consume;
    logic            halt_hit;
    logic            br_hit;

    branch_lut u_lut (
        .target_idx (Target_idx),
        .target     (br_target)
    );

    // A word is consumed only when it is live and downstream takes it.
    // Halt beats a same-cycle branch; squashed words can neither halt nor branch.
    assign live     = (state == RUN) && r.vld;
    assign consume  = live && !Stall;
    assign halt_hit = consume && (Rom_data == HALT_CODE);
    assign br_hit   = consume && Branch_taken && !halt_hit;

    // ---------------- state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = PRIME;
            PRIME:   state_nxt = RUN;
            RUN:     if (halt_hit) state_nxt = HALTED;
            HALTED:  if (Start) state_nxt = PRIME;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        r_nxt = r;
        case (state)
            IDLE, HALTED: begin
                if (Start) begin
                    r_nxt.pc  = START_ADDR;
                    r_nxt.vld = 1'b0;
                end
            end
            PRIME: begin
                r_nxt.instr_pc = r.pc;
                r_nxt.pc       = pc_inc(r.pc);
                r_nxt.vld      = 1'b1;
            end
            RUN: begin
                if (halt_hit) begin
                    r_nxt.vld = 1'b0;
                end else if (!Stall) begin
                    // The sequential word already in flight becomes the bubble
                    // on a redirect; the target arrives one cycle after it.
                    r_nxt.instr_pc = r.pc;
                    r_nxt.pc       = br_hit ? br_target : pc_inc(r.pc);
                    r_nxt.vld      = !br_hit;
                end
            end
            default: r_nxt = r;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r <= '0;
        else       r <= r_nxt;
    end

    // ---------------- outputs ----------------
    // While stalled the held address is re-read so Rom_data (and Instr) stay put.
    always_comb begin
        Rom_addr    = (state == RUN && Stall) ? r.instr_pc : r.pc;
        Instr       = Rom_data;
        Instr_valid = live;
        Instr_pc    = r.instr_pc;
        Prog_ctr    = r.pc;
        Done        = (state == HALTED);
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    logic                 Clk = 1'b0;
    logic                 Reset, Start, Stall, Branch_taken;
    logic [LUT_IDX_W-1:0] Target_idx;
    logic [PC_W-1:0]      Rom_addr, Instr_pc, Prog_ctr;
    logic [INSTR_W-1:0]   Rom_data, Instr;
    logic                 Instr_valid, Done;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic [PC_W-1:0]      lut_tgt;

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .Branch_taken(Branch_taken), .Target_idx(Target_idx),
        .Rom_addr(Rom_addr), .Rom_data(Rom_data), .Instr(Instr),
        .Instr_valid(Instr_valid), .Instr_pc(Instr_pc),
        .Prog_ctr(Prog_ctr), .Done(Done)
    );

    branch_lut u_lut_chk (.target_idx(lut_idx), .target(lut_tgt));

    always #5 Clk = ~Clk;

    // synchronous ROM model
    logic [INSTR_W-1:0] rom [0:1023];
    always @(posedge Clk) Rom_data <= rom[Rom_addr];

    typedef struct {
        int pc;
        int instr;
        int gap;        // cycles from previous consume (or Start) to arrival
        bit from_start;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   stall_map[int];
    int   br_map[int];
    int   m_cur;
    bit   m_running = 0, rand_mode = 0, mon_en = 0;
    int   cyc = 0, ref_cyc = 0, start_cyc = 0, done_cyc = -1;
    bit   arrived = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_target(input int idx);
        return (idx == 31) ? 'h3FE : idx * 8;
    endfunction

    task automatic fill_rom();
        for (int a = 0; a < 1024; a++) rom[a] = 9'($urandom_range(0, 510));
    endtask

    // Decide inputs for the coming edge; update the program-order model when
    // the presented word will be consumed.
    task automatic drive_body();
        bit   stl = 0, br = 0, st = 0;
        int   idx, nxt;
        exp_t e;
        idx = int'($urandom_range(0, 31));
        if (Instr_valid && m_running) begin
            if (stall_map.exists(m_cur) && stall_map[m_cur] > 0) begin
                stl = 1;
                stall_map[m_cur]--;
            end else if (rand_mode) stl = ($urandom_range(0, 3) == 0);
            if (br_map.exists(m_cur)) begin
                br  = 1;
                idx = br_map[m_cur];
            end else if (rand_mode) br = ($urandom_range(0, 4) == 0);
            if (rand_mode && !stl && $urandom_range(0, 19) == 0) st = 1;
            if (!stl) begin
                if (br_map.exists(m_cur)) br_map.delete(m_cur);
                if (rom[m_cur] == HALT_CODE) m_running = 0;
                else begin
                    nxt          = br ? ref_target(idx) : (m_cur + 1) % 1024;
                    e.pc         = nxt;
                    e.instr      = int'(rom[nxt]);
                    e.gap        = br ? 2 : 1;
                    e.from_start = 0;
                    q.push_back(e);
                    m_cur = nxt;
                end
            end
        end else if (rand_mode) br = ($urandom_range(0, 1) == 1);
        Stall        = stl;
        Branch_taken = br;
        Target_idx   = LUT_IDX_W'(idx);
        Start        = st;
    endtask

    task automatic drive_cycle();
        @(posedge Clk); #1;
        drive_body();
    endtask

    task automatic start_run();
        exp_t e;
        @(posedge Clk); #1;
        Start = 1; Stall = 0; Branch_taken = 0;
        m_cur = 0; m_running = 1;
        e.pc = 0; e.instr = int'(rom[0]); e.gap = 2; e.from_start = 1;
        q.push_back(e);
    endtask

    task automatic run_until_halt(input int budget);
        int n = 0;
        while (m_running && n < budget) begin
            drive_cycle();
            n++;
        end
        chk("halt_reached", 32'(m_running), 0);
        drive_cycle();
        drive_cycle();
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"},   Instr_valid, 0);
        chk({tag, "_prog_ctr"}, Prog_ctr,   0);
        chk({tag, "_instr_pc"}, Instr_pc,   0);
        chk({tag, "_done"},    Done,        0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk); #2;
            cyc++;
            if (!mon_en) begin
                arrived  = 0;
                done_cyc = -1;
                continue;
            end
            if (Start) start_cyc = cyc;
            if (cyc == done_cyc) begin
                chk("done_after_halt", Done, 1);
                chk("valid_while_halted", Instr_valid, 0);
            end
            if (Instr_valid) begin
                if (q.size() == 0) chk("unexpected_valid", Instr_valid, 0);
                else begin
                    e = q[0];
                    if (!arrived) begin
                        chk("arrival_gap", cyc - (e.from_start ? start_cyc : ref_cyc), e.gap);
                        arrived = 1;
                    end
                    chk("instr_pc", Instr_pc, e.pc);
                    chk("instr", Instr, e.instr);
                    chk("prog_ctr", Prog_ctr, (e.pc + 1) % 1024);
                    chk("done_low", Done, 0);
                    if (!Stall) begin
                        if (e.instr == int'(HALT_CODE)) done_cyc = cyc + 1;
                        ref_cyc = cyc;
                        arrived = 0;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        Reset = 1; Start = 0; Stall = 0; Branch_taken = 0; Target_idx = '0;
        lut_idx = '0;
        fill_rom();

        // standalone table lookup
        for (int i = 0; i < 32; i++) begin
            lut_idx = LUT_IDX_W'(i);
            #1;
            chk("branch_lut", lut_tgt, ref_target(i));
        end

        repeat (3) @(posedge Clk);
        #2;
        check_reset_state("reset");
        @(posedge Clk); #1;
        Reset  = 0;
        mon_en = 1;

        // A: straight-line program, halt with a same-cycle branch (halt wins)
        rom[0] = 9'h040; rom[1] = 9'h081; rom[2] = 9'h0C2; rom[3] = 9'h1FF;
        br_map[3] = 4;
        start_run();
        run_until_halt(100);
        chk("halted_prog_ctr", Prog_ctr, 4);
        br_map.delete();

        // B: stall, redirect with squashed halt in bubble, stall+branch, wrap at 3FF
        fill_rom();
        rom[6] = HALT_CODE;
        rom[10'h3FF] = HALT_CODE;
        stall_map[1] = 3;
        br_map[5] = 4;
        stall_map[10'h22] = 2;
        br_map[10'h22] = 31;
        start_run();
        run_until_halt(200);
        stall_map.delete();
        br_map.delete();

        // restart from HALTED: sequential run halts at word 6
        start_run();
        run_until_halt(200);

        // C: reset mid-run at Instr_pc=9; Start during Reset is ignored
        fill_rom();
        rom[20] = HALT_CODE;
        start_run();
        n = 0;
        forever begin
            @(posedge Clk); #1;
            if ((Instr_valid && m_cur == 9) || n >= 100) break;
            drive_body();
            n++;
        end
        chk("reach_pc9", Instr_pc, 9);
        mon_en = 0; q.delete(); m_running = 0;
        Reset = 1; Stall = 0; Branch_taken = 0; Start = 0;
        @(posedge Clk); #2;
        check_reset_state("midrun_reset");
        Start = 1;
        @(posedge Clk); #1;
        Start = 0; Reset = 0;
        repeat (3) @(posedge Clk);
        #2;
        check_reset_state("post_reset_idle");
        @(posedge Clk); #1;
        mon_en = 1;

        // D: randomized run with sprinkled halts and restarts
        fill_rom();
        for (int k = 0; k < 12; k++) rom[$urandom_range(0, 1023)] = HALT_CODE;
        rand_mode = 1;
        start_run();
        for (int i = 0; i < 1500; i++) begin
            if (!m_running) begin
                drive_cycle();
                start_run();
            end else drive_cycle();
        end
        rand_mode = 0;
        mon_en = 0;
        Reset = 1;
        @(posedge Clk); #2;
        check_reset_state("final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
